// File: rtl/md_window_accumulator.sv
// Sums WIN valid 2-bit samples per window and presents each window sum
// on a registered valid/ready output with sticky drop detection.
module md_window_accumulator #(
  parameter int WIN   = 4,
  parameter int SUM_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_VALID,
  input  logic [1:0]       IN_E,
  input  logic             IN_READY,
  output logic             OUT_VALID,
  output logic [SUM_W-1:0] OUT_SUM,
  output logic             OUT_OVERFLOW,
  output logic [CNT_W-1:0] OUT_WIN_CNT
);

  localparam int PW = (WIN > 2) ? $clog2(WIN) : 1;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             state;
  logic [SUM_W-1:0] acc;
  logic [PW-1:0]    cnt;
  logic [SUM_W-1:0] sum_nxt;
  logic             done;

  assign sum_nxt = acc + SUM_W'(IN_E);
  assign done    = IN_VALID && (cnt == PW'(WIN - 1));

  assign OUT_VALID = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      state        <= ST_EMPTY;
      OUT_SUM      <= '0;
      OUT_OVERFLOW <= 1'b0;
      OUT_WIN_CNT  <= '0;
    end else begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else if (IN_VALID) begin
        acc <= sum_nxt;
        cnt <= cnt + PW'(1);
      end

      case (state)
        ST_EMPTY: begin
          if (done) begin
            OUT_SUM <= sum_nxt;
            state   <= ST_FULL;
          end
        end
        default: begin
          // a completion while stalled has nowhere to go and is dropped
          if (IN_READY) begin
            OUT_WIN_CNT <= OUT_WIN_CNT + CNT_W'(1);
            if (done) OUT_SUM <= sum_nxt;
            else      state   <= ST_EMPTY;
          end else if (done) begin
            OUT_OVERFLOW <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
